// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: NPORTS SRAM-like request ports onto one AXI3 master.
// One outstanding transaction per port; the AXI ID is the port index, so
// out-of-order R/B responses route straight back to their owning port.
module sram_axi_bridge #(
  parameter int unsigned NPORTS   = 2,
  parameter int unsigned ID_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  // SRAM-like ports, port i owns slice i of each flattened bus
  input  logic [NPORTS-1:0]      port_req,
  input  logic [NPORTS-1:0]      port_wr,
  input  logic [2*NPORTS-1:0]    port_size,
  input  logic [32*NPORTS-1:0]   port_addr,
  input  logic [32*NPORTS-1:0]   port_wdata,
  input  logic [NPORTS-1:0]      port_uncached,
  output logic [NPORTS-1:0]      port_addr_ok,
  output logic [NPORTS-1:0]      port_data_ok,
  output logic [32*NPORTS-1:0]   port_rdata,
  // AXI3 read address
  output logic [ID_WIDTH-1:0]    arid,
  output logic [31:0]            araddr,
  output logic [3:0]             arlen,
  output logic [2:0]             arsize,
  output logic [1:0]             arburst,
  output logic [1:0]             arlock,
  output logic [3:0]             arcache,
  output logic [2:0]             arprot,
  output logic                   arvalid,
  input  logic                   arready,
  // AXI3 read data
  input  logic [ID_WIDTH-1:0]    rid,
  input  logic [31:0]            rdata,
  input  logic [1:0]             rresp,
  input  logic                   rlast,
  input  logic                   rvalid,
  output logic                   rready,
  // AXI3 write address
  output logic [ID_WIDTH-1:0]    awid,
  output logic [31:0]            awaddr,
  output logic [3:0]             awlen,
  output logic [2:0]             awsize,
  output logic [1:0]             awburst,
  output logic [1:0]             awlock,
  output logic [3:0]             awcache,
  output logic [2:0]             awprot,
  output logic                   awvalid,
  input  logic                   awready,
  // AXI3 write data
  output logic [ID_WIDTH-1:0]    wid,
  output logic [31:0]            wdata,
  output logic [3:0]             wstrb,
  output logic                   wlast,
  output logic                   wvalid,
  input  logic                   wready,
  // AXI3 write response
  input  logic [ID_WIDTH-1:0]    bid,
  input  logic [1:0]             bresp,
  input  logic                   bvalid,
  output logic                   bready
);

  localparam int unsigned PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_RESP = 3'd2,
    S_WR_ADDR = 3'd3,
    S_WR_RESP = 3'd4
  } state_t;

  state_t        state_q   [NPORTS];
  state_t        state_d   [NPORTS];
  logic [1:0]    size_q    [NPORTS];
  logic [31:0]   addr_q    [NPORTS];
  logic [31:0]   wdata_q   [NPORTS];
  logic [NPORTS-1:0] uncached_q;

  logic [NPORTS-1:0] ar_cand, aw_cand, r_hit, b_hit;
  logic          ar_found, aw_found;
  logic [PW-1:0] ar_pick, aw_pick, ar_gnt, aw_gnt;
  logic [PW-1:0] ar_ptr_q, aw_ptr_q, ar_lock_gnt_q, aw_lock_gnt_q;
  logic          ar_lock_q, aw_lock_q, aw_done_q, w_done_q;
  logic          ar_hs, aw_hs, w_hs, aw_complete;

  // Response status and single-beat framing carry no information here.
  logic unused_resp;
  assign unused_resp = ^{rresp, bresp, rlast};

  // Round-robin search starting at ptr; returns {found, index}.
  function automatic logic [PW:0] rr_pick(input logic [NPORTS-1:0] cand,
                                          input logic [PW-1:0] ptr);
    logic          found;
    logic [PW-1:0] sel;
    int unsigned   idx;
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NPORTS) idx = idx - NPORTS;
      if (!found && cand[PW'(idx)]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
    return {found, sel};
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] g);
    return ((32'(g) + 32'd1) >= NPORTS) ? '0 : g + PW'(1);
  endfunction

  function automatic logic [2:0] ax_size(input logic [1:0] s);
    return (s == 2'd3) ? 3'b010 : {1'b0, s};
  endfunction

  // Fixed AXI fields: single-beat INCR, normal access, always ready for responses.
  assign arlen   = 4'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arprot  = 3'b000;
  assign awlen   = 4'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awprot  = 3'b000;
  assign wlast   = 1'b1;
  assign rready  = 1'b1;
  assign bready  = 1'b1;

  // Request acceptance, arbitration candidates and response matching.
  always_comb begin
    port_addr_ok = '0;
    ar_cand      = '0;
    aw_cand      = '0;
    r_hit        = '0;
    b_hit        = '0;
    for (int i = 0; i < NPORTS; i++) begin
      port_addr_ok[i] = port_req[i] && (state_q[i] == S_IDLE);
      ar_cand[i]      = (state_q[i] == S_RD_ADDR);
      aw_cand[i]      = (state_q[i] == S_WR_ADDR);
      r_hit[i]        = rvalid && (rid == ID_WIDTH'(i)) && (state_q[i] == S_RD_RESP);
      b_hit[i]        = bvalid && (bid == ID_WIDTH'(i)) && (state_q[i] == S_WR_RESP);
    end
  end

  // AR channel: grant locked while arvalid waits so the payload stays stable.
  always_comb begin
    {ar_found, ar_pick} = rr_pick(ar_cand, ar_ptr_q);
    ar_gnt  = ar_lock_q ? ar_lock_gnt_q : ar_pick;
    arvalid = ar_lock_q | ar_found;
    ar_hs   = arvalid & arready;
    arid    = ID_WIDTH'(ar_gnt);
    araddr  = addr_q[ar_gnt];
    arsize  = ax_size(size_q[ar_gnt]);
    arcache = uncached_q[ar_gnt] ? 4'b0000 : 4'b1111;
  end

  // AW/W channels: raised together, each drops after its own handshake.
  always_comb begin
    {aw_found, aw_pick} = rr_pick(aw_cand, aw_ptr_q);
    aw_gnt      = aw_lock_q ? aw_lock_gnt_q : aw_pick;
    awvalid     = aw_lock_q ? !aw_done_q : aw_found;
    wvalid      = aw_lock_q ? !w_done_q  : aw_found;
    aw_hs       = awvalid & awready;
    w_hs        = wvalid & wready;
    aw_complete = (aw_done_q | aw_hs) & (w_done_q | w_hs);
    awid        = ID_WIDTH'(aw_gnt);
    wid         = ID_WIDTH'(aw_gnt);
    awaddr      = addr_q[aw_gnt];
    awsize      = ax_size(size_q[aw_gnt]);
    awcache     = uncached_q[aw_gnt] ? 4'b0000 : 4'b1111;
    wdata       = wdata_q[aw_gnt];
    case (size_q[aw_gnt])
      2'd0:    wstrb = 4'b0001 << addr_q[aw_gnt][1:0];
      2'd1:    wstrb = 4'b0011 << addr_q[aw_gnt][1:0];
      default: wstrb = 4'b1111;
    endcase
  end

  // Per-port next state.
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        S_IDLE:    if (port_req[i]) state_d[i] = port_wr[i] ? S_WR_ADDR : S_RD_ADDR;
        S_RD_ADDR: if (ar_hs && (ar_gnt == PW'(i))) state_d[i] = S_RD_RESP;
        S_RD_RESP: if (r_hit[i]) state_d[i] = S_IDLE;
        S_WR_ADDR: if (aw_complete && (aw_gnt == PW'(i))) state_d[i] = S_WR_RESP;
        S_WR_RESP: if (b_hit[i]) state_d[i] = S_IDLE;
        default:   state_d[i] = S_IDLE;
      endcase
    end
  end

  // Per-port state, request capture and completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPORTS; i++) begin
        state_q[i] <= S_IDLE;
        size_q[i]  <= '0;
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
      end
      uncached_q   <= '0;
      port_data_ok <= '0;
      port_rdata   <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        state_q[i]      <= state_d[i];
        port_data_ok[i] <= r_hit[i] | b_hit[i];
        if (port_addr_ok[i]) begin
          size_q[i]     <= port_size[2*i +: 2];
          addr_q[i]     <= port_addr[32*i +: 32];
          wdata_q[i]    <= port_wdata[32*i +: 32];
          uncached_q[i] <= port_uncached[i];
        end
        if (r_hit[i]) port_rdata[32*i +: 32] <= rdata;
      end
    end
  end

  // Arbiter pointers, grant locks and AW/W handshake tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_ptr_q      <= '0;
      ar_lock_q     <= 1'b0;
      ar_lock_gnt_q <= '0;
      aw_ptr_q      <= '0;
      aw_lock_q     <= 1'b0;
      aw_lock_gnt_q <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
    end else begin
      if (arvalid) begin
        if (arready) begin
          ar_lock_q <= 1'b0;
          ar_ptr_q  <= next_ptr(ar_gnt);
        end else begin
          ar_lock_q     <= 1'b1;
          ar_lock_gnt_q <= ar_gnt;
        end
      end
      if (aw_complete) begin
        aw_lock_q <= 1'b0;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        aw_ptr_q  <= next_ptr(aw_gnt);
      end else if (awvalid || wvalid) begin
        aw_lock_q     <= 1'b1;
        aw_lock_gnt_q <= aw_gnt;
        aw_done_q     <= aw_done_q | aw_hs;
        w_done_q      <= w_done_q | w_hs;
      end
    end
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge (2 ports, 4-bit IDs) with a hand-driven AXI slave.
module tb_sram_axi_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   port_req, port_wr, port_uncached, port_addr_ok, port_data_ok;
  logic [3:0]   port_size;
  logic [63:0]  port_addr, port_wdata, port_rdata;
  logic [3:0]   arid, awid, wid, rid, bid;
  logic [31:0]  araddr, awaddr, wdata, rdata;
  logic [3:0]   arlen, awlen, arcache, awcache, wstrb;
  logic [2:0]   arsize, awsize, arprot, awprot;
  logic [1:0]   arburst, awburst, arlock, awlock, rresp, bresp;
  logic         arvalid, arready, awvalid, awready, wvalid, wready, wlast;
  logic         rvalid, rready, rlast, bvalid, bready;

  int n_checks = 0;
  int n_fail   = 0;

  sram_axi_bridge dut (
    .clk(clk), .rst(rst),
    .port_req(port_req), .port_wr(port_wr), .port_size(port_size),
    .port_addr(port_addr), .port_wdata(port_wdata), .port_uncached(port_uncached),
    .port_addr_ok(port_addr_ok), .port_data_ok(port_data_ok), .port_rdata(port_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive phase of the next cycle: just after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Sample phase: well clear of both edges.
  task automatic smp();
    #3;
  endtask

  task automatic clear_ports();
    port_req = '0; port_wr = '0; port_uncached = '0;
  endtask

  task automatic set_port(input int p, input logic wr, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d, input logic unc);
    port_req[p] = 1'b1;
    port_wr[p]  = wr;
    port_size[2*p +: 2]   = sz;
    port_addr[32*p +: 32] = a;
    port_wdata[32*p +: 32] = d;
    port_uncached[p] = unc;
  endtask

  // Single uncontended word read on port p with immediate ready/response.
  task automatic read_one(input int p, input logic [31:0] a, input logic [31:0] d);
    logic [1:0] one;
    one = 2'b01 << p;
    cyc(); clear_ports(); set_port(p, 1'b0, 2'd2, a, 32'h0, 1'b0);
    smp(); check("rd_addr_ok", port_addr_ok, one);
    cyc(); clear_ports(); arready = 1'b1;
    smp(); check("rd_arvalid", arvalid, 1); check("rd_arid", arid, p); check("rd_araddr", araddr, a);
    check("rd_arsize", arsize, 3'd2); check("rd_arcache", arcache, 4'hF);
    cyc(); arready = 1'b0; rvalid = 1'b1; rid = 4'(p); rdata = d;
    smp(); check("rd_arvalid_low", arvalid, 0); check("rd_no_early_ok", port_data_ok, 0);
    cyc(); rvalid = 1'b0;
    smp(); check("rd_data_ok", port_data_ok, one); check("rd_rdata", port_rdata[32*p +: 32], d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clear_ports(); port_size = '0; port_addr = '0; port_wdata = '0;
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
    rid = '0; bid = '0; rdata = '0; rresp = 2'b00; bresp = 2'b00; rlast = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;

    // Reset state
    smp();
    check("rst_arvalid", arvalid, 0); check("rst_awvalid", awvalid, 0); check("rst_wvalid", wvalid, 0);
    check("rst_data_ok", port_data_ok, 0); check("rst_rdata", port_rdata, 64'h0);
    check("rst_rready", rready, 1); check("rst_bready", bready, 1);

    // Port0 boot read, constant AR fields
    read_one(0, 32'h1FC0_0000, 32'hDEAD_BEEF);
    check("arlen", arlen, 0); check("arburst", arburst, 2'b01); check("arlock", arlock, 0); check("arprot", arprot, 0);
    cyc(); smp(); check("rdata_held", port_rdata[31:0], 32'hDEAD_BEEF); check("ok_pulse_one_cycle", port_data_ok, 0);

    // Port1 uncached byte write at offset 3
    cyc(); clear_ports(); set_port(1, 1'b1, 2'd0, 32'h8000_0003, 32'hAB00_0000, 1'b1);
    smp(); check("bw_addr_ok", port_addr_ok, 2'b10);
    cyc(); clear_ports(); awready = 1; wready = 1;
    smp(); check("bw_awvalid", awvalid, 1); check("bw_wvalid", wvalid, 1); check("bw_awid", awid, 1);
    check("bw_wid", wid, 1); check("bw_awcache", awcache, 0); check("bw_wstrb", wstrb, 4'b1000);
    check("bw_wdata", wdata, 32'hAB00_0000); check("bw_awsize", awsize, 0); check("bw_awaddr", awaddr, 32'h8000_0003);
    check("bw_wlast", wlast, 1); check("bw_awburst", awburst, 2'b01);
    cyc(); awready = 0; wready = 0; bvalid = 1; bid = 4'd1;
    smp(); check("bw_valids_low", {awvalid, wvalid}, 2'b00); check("bw_no_early_ok", port_data_ok, 0);
    cyc(); bvalid = 0;
    smp(); check("bw_data_ok", port_data_ok, 2'b10);

    // Port0 half write: W accepted at once, AW delayed to cycle 4
    cyc(); clear_ports(); set_port(0, 1'b1, 2'd1, 32'h0000_0042, 32'h5678_0000, 1'b0);
    smp(); check("hw_addr_ok", port_addr_ok, 2'b01);
    cyc(); clear_ports(); wready = 1;
    smp(); check("hw_c1_valids", {awvalid, wvalid}, 2'b11); check("hw_wstrb", wstrb, 4'b1100);
    check("hw_awsize", awsize, 3'd1); check("hw_awcache", awcache, 4'hF);
    cyc(); wready = 0;
    smp(); check("hw_c2_valids", {awvalid, wvalid}, 2'b10); check("hw_awaddr", awaddr, 32'h42);
    cyc();
    smp(); check("hw_c3_valids", {awvalid, wvalid}, 2'b10);
    cyc(); awready = 1;
    smp(); check("hw_c4_valids", {awvalid, wvalid}, 2'b10);
    cyc(); awready = 0; bvalid = 1; bid = 4'd0;
    smp(); check("hw_c5_valids", {awvalid, wvalid}, 2'b00);
    cyc(); bvalid = 0;
    smp(); check("hw_data_ok", port_data_ok, 2'b01);

    // Reset while port0 waits in RD_RESP, then an immediate new read with a stray ID
    cyc(); clear_ports(); set_port(0, 1'b0, 2'd2, 32'h300, 32'h0, 1'b0);
    cyc(); clear_ports(); arready = 1;
    smp(); check("rr_arvalid", arvalid, 1);
    cyc(); arready = 0; rst = 1;
    cyc(); rst = 0; set_port(0, 1'b0, 2'd2, 32'h304, 32'h0, 1'b0);
    smp(); check("rr_valids", {arvalid, awvalid, wvalid}, 3'b000); check("rr_data_ok", port_data_ok, 0);
    check("rr_rdata_cleared", port_rdata, 64'h0); check("rr_addr_ok", port_addr_ok, 2'b01);
    cyc(); clear_ports(); arready = 1;
    smp(); check("rr_arvalid2", arvalid, 1); check("rr_araddr", araddr, 32'h304); check("rr_arid", arid, 0);
    cyc(); arready = 0; rvalid = 1; rid = 4'd5; rdata = 32'hFFFF_FFFF;
    cyc(); rid = 4'd0; rdata = 32'h0BAD_F00D;
    smp(); check("stray_id_dropped", port_data_ok, 0);
    cyc(); rvalid = 0;
    smp(); check("rr_data_ok2", port_data_ok, 2'b01); check("rr_rdata2", port_rdata[31:0], 32'h0BAD_F00D);

    // Pointer is now 1; a port1 read brings it back to 0
    read_one(1, 32'h400, 32'hCAFE_0001);

    // Contention at pointer 0: port0 then port1; responses return rid 1 then rid 0
    cyc(); clear_ports(); set_port(0, 1'b0, 2'd2, 32'h100, 32'h0, 1'b0); set_port(1, 1'b0, 2'd2, 32'h200, 32'h0, 1'b0);
    smp(); check("c1_addr_ok", port_addr_ok, 2'b11);
    cyc(); clear_ports(); arready = 1;
    smp(); check("c1_first_id", arid, 0); check("c1_first_addr", araddr, 32'h100);
    cyc();
    smp(); check("c1_second_id", arid, 1); check("c1_second_addr", araddr, 32'h200); check("c1_second_valid", arvalid, 1);
    cyc(); arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'h1111_1111;
    smp(); check("c1_ar_done", arvalid, 0);
    cyc(); rid = 4'd0; rdata = 32'h2222_2222;
    smp(); check("ooo_ok1", port_data_ok, 2'b10); check("ooo_rdata1", port_rdata[63:32], 32'h1111_1111);
    cyc(); rvalid = 0;
    smp(); check("ooo_ok0", port_data_ok, 2'b01); check("ooo_rdata0", port_rdata[31:0], 32'h2222_2222);
    check("ooo_rdata1_held", port_rdata[63:32], 32'h1111_1111);

    // A port0 read moves the pointer to 1, so the next contention favours port1
    read_one(0, 32'h480, 32'hCAFE_0000);
    cyc(); clear_ports(); set_port(0, 1'b0, 2'd3, 32'h500, 32'h0, 1'b0); set_port(1, 1'b0, 2'd2, 32'h600, 32'h0, 1'b0);
    cyc(); clear_ports(); arready = 1;
    smp(); check("c2_first_id", arid, 1); check("c2_first_addr", araddr, 32'h600);
    cyc();
    smp(); check("c2_second_id", arid, 0); check("c2_size3_as_word", arsize, 3'd2);
    cyc(); arready = 0; rvalid = 1; rid = 4'd0; rdata = 32'h3333_3333;
    cyc(); rid = 4'd1; rdata = 32'h4444_4444;
    smp(); check("c2_ok0", port_data_ok, 2'b01);
    cyc(); rvalid = 0;
    smp(); check("c2_ok1", port_data_ok, 2'b10); check("c2_rdata", port_rdata, 64'h4444_4444_3333_3333);

    // Port0 read and port1 write complete in the same cycle
    cyc(); clear_ports(); set_port(0, 1'b0, 2'd2, 32'h700, 32'h0, 1'b0); set_port(1, 1'b1, 2'd2, 32'h800, 32'h9999_0000, 1'b0);
    cyc(); clear_ports(); arready = 1; awready = 1; wready = 1;
    smp(); check("rb_ar_aw", {arvalid, awvalid, wvalid}, 3'b111); check("rb_awid", awid, 1); check("rb_arid", arid, 0);
    cyc(); arready = 0; awready = 0; wready = 0; rvalid = 1; rid = 4'd0; rdata = 32'h7777_7777; bvalid = 1; bid = 4'd1;
    cyc(); rvalid = 0; bvalid = 0;
    smp(); check("rb_both_ok", port_data_ok, 2'b11); check("rb_rdata0", port_rdata[31:0], 32'h7777_7777);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
